// File: rtl/csi_tx_packer.sv
// CSI-2 two-lane transmit packer: frame start/end short packets and long pixel packets
// with header ECC, payload pass-through, CRC-16 trailer and an inter-packet idle gap.
module csi_tx_packer #(
  parameter logic [7:0]  DT_PIX    = 8'h2B,
  parameter logic [1:0]  VC        = 2'd0,
  parameter int unsigned GAP_CYC   = 4,
  parameter logic [15:0] FCNT_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fs_req,
  input  logic        fe_req,
  input  logic        ln_req,
  input  logic [15:0] ln_wc,
  input  logic [15:0] pix_dat,
  input  logic        pix_vld,
  output logic        pix_rdy,
  output logic [15:0] tx_dat,
  output logic        tx_vld,
  output logic        busy,
  output logic        err
);

  localparam int unsigned WC_W  = 16;
  localparam int unsigned GAP_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR0, ST_HDR1, ST_PAYLOAD, ST_CRC, ST_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        di_q, di_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic [7:0]        ecc_q, ecc_d;
  logic [WC_W-1:0]   rem_q, rem_d;
  logic [15:0]       crc_q, crc_d;
  logic [WC_W-1:0]   fcnt_q, fcnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              long_q, long_d;
  logic              err_q, err_d;

  logic [7:0]        hdr_di;
  logic [WC_W-1:0]   hdr_wc;
  logic              hdr_go;

  // CSI-2 header Hamming parity over {WC_hi, WC_lo, DI}
  function automatic logic [7:0] ecc_calc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return {2'b00, p};
  endfunction

  // Reflected CRC-16 (0x8408) over one byte, LSB first
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      di_q    <= 8'h00;
      wc_q    <= '0;
      ecc_q   <= 8'h00;
      rem_q   <= '0;
      crc_q   <= 16'hFFFF;
      fcnt_q  <= FCNT_INIT;
      gap_q   <= '0;
      long_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      di_q    <= di_d;
      wc_q    <= wc_d;
      ecc_q   <= ecc_d;
      rem_q   <= rem_d;
      crc_q   <= crc_d;
      fcnt_q  <= fcnt_d;
      gap_q   <= gap_d;
      long_q  <= long_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    di_d    = di_q;
    wc_d    = wc_q;
    ecc_d   = ecc_q;
    rem_d   = rem_q;
    crc_d   = crc_q;
    fcnt_d  = fcnt_q;
    gap_d   = gap_q;
    long_d  = long_q;
    err_d   = 1'b0;
    hdr_di  = 8'h00;
    hdr_wc  = '0;
    hdr_go  = 1'b0;
    tx_vld  = 1'b0;
    tx_dat  = 16'h0000;
    pix_rdy = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // fe > fs > ln; frame number never takes the value 0 once counting
        if (fe_req) begin
          hdr_di = {VC, 6'h01};
          hdr_wc = fcnt_q;
          hdr_go = 1'b1;
          long_d = 1'b0;
        end else if (fs_req) begin
          hdr_wc = (fcnt_q == 16'hFFFF) ? 16'h0001 : WC_W'(fcnt_q + 16'h0001);
          fcnt_d = hdr_wc;
          hdr_di = {VC, 6'h00};
          hdr_go = 1'b1;
          long_d = 1'b0;
        end else if (ln_req) begin
          if (ln_wc[0]) begin
            err_d = 1'b1;
          end else begin
            hdr_di = {VC, DT_PIX[5:0]};
            hdr_wc = ln_wc;
            rem_d  = ln_wc;
            crc_d  = 16'hFFFF;
            long_d = 1'b1;
            hdr_go = 1'b1;
          end
        end
        if (hdr_go) begin
          di_d    = hdr_di;
          wc_d    = hdr_wc;
          ecc_d   = ecc_calc({hdr_wc, hdr_di});
          state_d = ST_HDR0;
        end
      end
      ST_HDR0: begin
        tx_vld  = 1'b1;
        tx_dat  = {wc_q[7:0], di_q};
        state_d = ST_HDR1;
      end
      ST_HDR1: begin
        tx_vld = 1'b1;
        tx_dat = {ecc_q, wc_q[15:8]};
        if (!long_q) begin
          gap_d   = GAP_W'(GAP_CYC - 1);
          state_d = ST_GAP;
        end else if (rem_q == '0) begin
          state_d = ST_CRC;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        // A stalled source mid-packet cannot be held in HS mode: abort without CRC
        pix_rdy = 1'b1;
        if (pix_vld) begin
          tx_vld = 1'b1;
          tx_dat = pix_dat;
          crc_d  = crc_byte(crc_byte(crc_q, pix_dat[7:0]), pix_dat[15:8]);
          rem_d  = WC_W'(rem_q - 16'd2);
          if (rem_q == 16'd2) begin
            state_d = ST_CRC;
          end
        end else begin
          err_d   = 1'b1;
          gap_d   = GAP_W'(GAP_CYC - 1);
          state_d = ST_GAP;
        end
      end
      ST_CRC: begin
        tx_vld  = 1'b1;
        tx_dat  = crc_q;
        gap_d   = GAP_W'(GAP_CYC - 1);
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = GAP_W'(gap_q - 4'd1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_csi_tx_packer.sv
// Scoreboard bench for csi_tx_packer: stimulus pushes expected lane words, a negedge
// monitor pops and compares every tx_vld cycle and checks idle words are zero.
module tb_csi_tx_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fs_req = 1'b0;
  logic        fe_req = 1'b0;
  logic        ln_req = 1'b0;
  logic [15:0] ln_wc = 16'h0000;
  logic [15:0] pix_dat = 16'h0000;
  logic        pix_vld = 1'b0;
  logic        pix_rdy, tx_vld, busy, err;
  logic [15:0] tx_dat;
  logic        w_pix_rdy, w_tx_vld, w_busy, w_err;
  logic [15:0] w_tx_dat;

  int checks = 0;
  int failures = 0;
  int tx_cnt = 0;
  int err_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  logic [15:0] fcnt_m = 16'h0000;

  localparam logic [23:0] ECC_M [6] = '{24'hF12CB7, 24'hF2555B, 24'h749A6D,
                                       24'hB8E38E, 24'hDF03F0, 24'hEFFC00};

  csi_tx_packer dut (
    .clk(clk), .reset(reset), .fs_req(fs_req), .fe_req(fe_req), .ln_req(ln_req),
    .ln_wc(ln_wc), .pix_dat(pix_dat), .pix_vld(pix_vld), .pix_rdy(pix_rdy),
    .tx_dat(tx_dat), .tx_vld(tx_vld), .busy(busy), .err(err)
  );

  // Second instance starts its frame counter near the top to reach the wrap quickly
  csi_tx_packer #(.FCNT_INIT(16'hFFFE)) u_wrap (
    .clk(clk), .reset(reset), .fs_req(fs_req), .fe_req(fe_req), .ln_req(ln_req),
    .ln_wc(ln_wc), .pix_dat(pix_dat), .pix_vld(pix_vld), .pix_rdy(w_pix_rdy),
    .tx_dat(w_tx_dat), .tx_vld(w_tx_vld), .busy(w_busy), .err(w_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  function automatic logic [7:0] ecc_m(input logic [23:0] d);
    logic [7:0] e;
    e = 8'h00;
    for (int k = 0; k < 6; k++) e[k] = ^(d & ECC_M[k]);
    return e;
  endfunction

  function automatic logic [15:0] crc_m(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int b = 0; b < 16; b++) begin
      fb = r[0] ^ w[b];
      r = r >> 1;
      if (fb) r = r ^ 16'h8408;
    end
    return r;
  endfunction

  function automatic logic [15:0] word_of(input int i);
    return 16'(i * 515 + 4660);
  endfunction

  always @(negedge clk) begin
    if (tx_vld) begin
      tx_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected actual=%0h required=no_word", tx_dat);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tx_dat", 32'(tx_dat), 32'(mon_e));
      end
    end else begin
      chk("tx_idle_zero", 32'(tx_dat), 32'h0);
    end
    if (err) err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 64) begin
      tick();
      n++;
    end
    chk(nm, 32'(busy), 32'h0);
  endtask

  task automatic push_short(input logic [5:0] dt, input logic [15:0] wc);
    logic [7:0] di;
    di = {2'b00, dt};
    exp_q.push_back({wc[7:0], di});
    exp_q.push_back({ecc_m({wc, di}), wc[15:8]});
  endtask

  // mode 0: full packet; 1: drop pix_vld after 'stop' words; 2: reset while word 'stop' is on the bus
  task automatic send_long(input int wc, input int mode, input int stop);
    int nw, i, cyc, npush;
    logic hs;
    logic [15:0] crc, w16;
    nw = wc / 2;
    w16 = 16'(wc);
    exp_q.push_back({w16[7:0], 8'h2B});
    exp_q.push_back({ecc_m({w16, 8'h2B}), w16[15:8]});
    npush = (mode == 0) ? nw : ((mode == 1) ? stop : stop + 1);
    crc = 16'hFFFF;
    for (int k = 0; k < nw; k++) crc = crc_m(crc, word_of(k));
    for (int k = 0; k < npush; k++) exp_q.push_back(word_of(k));
    if (mode == 0) exp_q.push_back(crc);
    pix_dat = word_of(0);
    pix_vld = 1'b1;
    ln_wc = w16;
    ln_req = 1'b1;
    tick();
    ln_req = 1'b0;
    i = 0;
    cyc = 0;
    while (i < nw && cyc < 2000) begin
      if (mode != 0 && i == stop) break;
      @(negedge clk);
      hs = pix_rdy && pix_vld;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) begin
        i++;
        pix_dat = word_of(i);
      end
    end
    if (mode == 0) begin
      chk("hs_count", 32'(i), 32'(nw));
      pix_vld = 1'b0;
      pix_dat = 16'h0000;
    end else if (mode == 1) begin
      pix_vld = 1'b0;
      @(negedge clk);
      chk("abort_vld_drop", 32'(tx_vld), 32'h0);
      @(posedge clk);
      #1;
      chk("abort_err", 32'(err), 32'h1);
      pix_dat = 16'h0000;
    end else begin
      reset = 1'b1;
      tick();
      chk("rst_abort_vld", 32'(tx_vld), 32'h0);
      chk("rst_abort_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      pix_vld = 1'b0;
      pix_dat = 16'h0000;
      fcnt_m = 16'h0000;
    end
  endtask

  initial begin
    int e0, t0;
    logic [6:0] bv;

    repeat (3) tick();
    chk("rst_tx_vld", 32'(tx_vld), 32'h0);
    chk("rst_pix_rdy", 32'(pix_rdy), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_tx_dat", 32'(tx_dat), 32'h0);
    reset = 1'b0;
    tick();

    // First frame start: DI 0x00, WC 1, ECC 0x1A, then four idle gap cycles
    t0 = tx_cnt;
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h1A00);
    fcnt_m = 16'h0001;
    fs_req = 1'b1;
    tick();
    fs_req = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bv[k] = busy;
      tick();
    end
    chk("fs_busy_profile", 32'(bv), 32'h3F);
    chk("fs_tx_count", 32'(tx_cnt - t0), 32'd2);

    // Empty long packet: header plus CRC seed
    exp_q.push_back(16'h002B);
    exp_q.push_back(16'h1700);
    exp_q.push_back(16'hFFFF);
    ln_wc = 16'h0000;
    ln_req = 1'b1;
    tick();
    ln_req = 1'b0;
    wait_idle("ln0_idle");

    // Frame end reuses current frame number
    push_short(6'h01, fcnt_m);
    fe_req = 1'b1;
    tick();
    fe_req = 1'b0;
    wait_idle("fe_idle");

    // Odd word count rejected
    e0 = err_cnt;
    t0 = tx_cnt;
    ln_wc = 16'd5;
    ln_req = 1'b1;
    tick();
    ln_req = 1'b0;
    chk("odd_err_pulse", 32'(err), 32'h1);
    chk("odd_tx_vld", 32'(tx_vld), 32'h0);
    chk("odd_busy", 32'(busy), 32'h0);
    tick();
    chk("odd_err_clear", 32'(err), 32'h0);
    chk("odd_err_count", 32'(err_cnt - e0), 32'd1);
    chk("odd_no_tx", 32'(tx_cnt - t0), 32'd0);

    // FS wins over simultaneous LN; LN during GAP dropped
    fcnt_m = 16'(fcnt_m + 16'd1);
    push_short(6'h00, fcnt_m);
    ln_wc = 16'd4;
    fs_req = 1'b1;
    ln_req = 1'b1;
    tick();
    fs_req = 1'b0;
    ln_req = 1'b0;
    tick();
    tick();
    ln_req = 1'b1;
    tick();
    ln_req = 1'b0;
    wait_idle("gap_idle");
    repeat (3) tick();
    chk("gap_req_ignored", 32'(exp_q.size()), 32'd0);
    chk("gap_req_busy", 32'(busy), 32'h0);

    // 640-byte line
    t0 = tx_cnt;
    send_long(640, 0, 0);
    wait_idle("ln640_idle");
    chk("ln640_tx_count", 32'(tx_cnt - t0), 32'd323);

    send_long(6, 0, 0);
    wait_idle("ln6_idle");
    send_long(2, 0, 0);
    wait_idle("ln2_idle");

    // Source stall mid-payload aborts without CRC
    e0 = err_cnt;
    send_long(8, 1, 2);
    wait_idle("abort_idle");
    chk("abort_err_count", 32'(err_cnt - e0), 32'd1);

    // Reset mid-payload
    send_long(8, 2, 2);
    tick();
    chk("rst_mid_queue", 32'(exp_q.size()), 32'd0);

    // Frame counter wrap (65535 -> 1) seen on the preloaded instance
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    fcnt_m = 16'h0001;
    push_short(6'h00, fcnt_m);
    fs_req = 1'b1;
    tick();
    fs_req = 1'b0;
    chk("wrap_ffff_hdr0", 32'(w_tx_dat), 32'h0000FF00);
    chk("wrap_ffff_vld", 32'(w_tx_vld), 32'h1);
    chk("wrap_busy", 32'(w_busy), 32'h1);
    chk("wrap_pix_rdy", 32'(w_pix_rdy), 32'h0);
    chk("wrap_err", 32'(w_err), 32'h0);
    wait_idle("wrap1_idle");
    tick();
    fcnt_m = 16'h0002;
    push_short(6'h00, fcnt_m);
    fs_req = 1'b1;
    tick();
    fs_req = 1'b0;
    chk("wrap_0001_hdr0", 32'(w_tx_dat), 32'h00000100);
    wait_idle("wrap2_idle");
    repeat (2) tick();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
